pipe_hazard_ctrl: RTL

Hazard and forwarding controller that drives the ID/EXE pipeline register of the 5-stage MIPS pipeline from the ID side.
- Tracks the destinations of the two instructions ahead of ID in an internal shadow pipeline.
- Generates the forwarding selects that the ID/EXE register latches.
- Detects load-use hazards and inserts one bubble; flushes IF/ID on taken control transfers.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ID-side hazard and forwarding controller for the 5-stage pipeline.
// Shadows the two instructions ahead of ID to pick forwarding sources and insert load-use bubbles.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_useA,
  input  logic             ID_useB,
  input  logic             ID_RegW,
  input  logic             ID_RegW_Src,
  input  logic [4:0]       ID_WBdst,
  input  logic             ID_stopNext,
  output logic [1:0]       ID_AluAsrc,
  output logic [1:0]       ID_FwdB,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             bubble_ID_EXE,
  output logic             flush_IF_ID,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t     state_reg, state_next;
  logic       e_v_reg, e_regw_reg, e_load_reg;
  logic [4:0] e_dst_reg;
  logic       m_v_reg, m_regw_reg;
  logic [4:0] m_dst_reg;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic [4:0] src   [2];
  logic [1:0] use_op;
  logic [1:0] hit_e, hit_m;
  logic [1:0] fwd   [2];
  logic       lu, stall, flush;

  assign src[0] = ID_rs;
  assign src[1] = ID_rt;
  assign use_op = {ID_useB, ID_useA};

  // Operand 0 is rs, operand 1 is rt; the nearer producer always wins.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign hit_e[gi] = e_v_reg & e_regw_reg & (e_dst_reg == src[gi]) & (src[gi] != 5'd0);
      assign hit_m[gi] = m_v_reg & m_regw_reg & (m_dst_reg == src[gi]) & (src[gi] != 5'd0);
      always_comb begin
        fwd[gi] = 2'b00;
        if (use_op[gi]) begin
          if (hit_e[gi])      fwd[gi] = 2'b01;
          else if (hit_m[gi]) fwd[gi] = 2'b10;
        end
      end
    end
  endgenerate

  assign ID_AluAsrc = fwd[0];
  assign ID_FwdB    = fwd[1];

  assign lu = ID_valid & e_load_reg & |(use_op & hit_e);

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    case (state_reg)
      RUN: begin
        if (lu && !hold) begin
          stall      = 1'b1;
          state_next = LU_STALL;
        end
      end
      LU_STALL: begin
        // E holds the bubble now, so the dependent instruction forwards from M.
        if (!hold) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign flush         = ID_valid & ID_stopNext & ~stall & ~hold;
  assign stall_PC      = stall;
  assign stall_IF_ID   = stall;
  assign bubble_ID_EXE = stall;
  assign flush_IF_ID   = flush;
  assign stall_cnt     = stall_cnt_reg;
  assign flush_cnt     = flush_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      e_v_reg       <= 1'b0;
      e_regw_reg    <= 1'b0;
      e_load_reg    <= 1'b0;
      e_dst_reg     <= 5'd0;
      m_v_reg       <= 1'b0;
      m_regw_reg    <= 1'b0;
      m_dst_reg     <= 5'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (!hold) begin
      state_reg  <= state_next;
      m_v_reg    <= e_v_reg;
      m_regw_reg <= e_regw_reg;
      m_dst_reg  <= e_dst_reg;
      if (stall || !ID_valid) begin
        e_v_reg    <= 1'b0;
        e_regw_reg <= 1'b0;
        e_load_reg <= 1'b0;
        e_dst_reg  <= 5'd0;
      end else begin
        e_v_reg    <= 1'b1;
        e_regw_reg <= ID_RegW;
        e_load_reg <= ID_RegW_Src;
        e_dst_reg  <= ID_WBdst;
      end
      if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

endmodule
